waveform_packetizer: RTL



---
 rtl/waveform_pkg.sv | 34 +++
 rtl/axis_out_reg.sv | 67 ++++++
 rtl/waveform_packetizer.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/waveform_pkg.sv
// ----------------------------------------------------------------------------
// waveform_pkg
// Shared definitions for the waveform link framing. Both the transmit side
// (waveform_packetizer) and the receive side (waveform_formatter) import this
// package so the command word, header layout and FSM encoding stay in step.
//
// Contents:
//   WFRM_CMD_WORD   - header word 0 of every packet
//   WFRM_HDR_WORDS  - number of header words per packet
//   HDR_IDX_*       - position of each field inside the header
//   wfrm_state_e    - packetizer FSM states; ST_TRAIL exists only when
//                     WFPKT_CHECKSUM_EN is defined
// ----------------------------------------------------------------------------
package waveform_pkg;

    localparam logic [31:0] WFRM_CMD_WORD  = 32'h5757_4441;
    localparam int unsigned WFRM_HDR_WORDS = 5;

    localparam logic [2:0] HDR_IDX_CMD   = 3'd0;
    localparam logic [2:0] HDR_IDX_ID    = 3'd1;
    localparam logic [2:0] HDR_IDX_INDEX = 3'd2;
    localparam logic [2:0] HDR_IDX_LEN   = 3'd3;
    localparam logic [2:0] HDR_IDX_LAST  = 3'(WFRM_HDR_WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HDR     = 2'd1,
        ST_PAYLOAD = 2'd2
`ifdef WFPKT_CHECKSUM_EN
        , ST_TRAIL = 2'd3
`endif
    } wfrm_state_e;

endpackage

// File: rtl/axis_out_reg.sv
// ----------------------------------------------------------------------------
// axis_out_reg
// Single-slot AXI-Stream output register. A word offered on in_* is taken
// whenever the slot is empty or the current word is leaving this cycle, so a
// continuously ready sink sees one word per cycle. Once out_valid is high the
// data/last fields hold until out_ready.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_data/in_last  word offered by the producer
//   in_ready              slot can take a word this cycle
//   out_valid/out_data/out_last/out_keep  registered AXIS master side
//   out_ready             downstream ready
// ----------------------------------------------------------------------------
module axis_out_reg #(
    parameter int unsigned DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [DATA_W-1:0]     in_data,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [DATA_W-1:0]     out_data,
    output logic                  out_last,
    output logic [DATA_W/8-1:0]   out_keep,
    input  logic                  out_ready
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic              last_q,  last_d;

    assign in_ready = !valid_q || out_ready;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        last_d  = last_q;
        if (in_ready) begin
            valid_d = in_valid;
            last_d  = in_valid && in_last;
            if (in_valid) begin
                data_d = in_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_last  = last_q;
    assign out_keep  = {(DATA_W/8){valid_q}};

endmodule

// File: rtl/waveform_packetizer.sv
// ----------------------------------------------------------------------------
// waveform_packetizer
// Frames a raw 32-bit sample stream into waveform packets: a 5-word header
// (command, waveform id, chunk index, chunk length, 0) followed by up to
// CHUNK_WORDS payload words. Long waveforms are split into several chunks.
//
// Optional feature (macro WFPKT_CHECKSUM_EN): each packet ends with a trailer
// word holding the wrapping 32-bit sum of its payload, and tlast moves there.
//
// Ports:
//   axi_tclk, axi_tresetn   clock, asynchronous active-low reset
//   start, wfrm_len         begin a waveform of wfrm_len payload words
//   busy                    waveform in progress
//   wfrm_id                 id stamped into packets, bumps on completion
//   smpl_axis_*             raw sample input (no tlast)
//   wfrm_axis_*             framed packet output
// ----------------------------------------------------------------------------
module waveform_packetizer
    import waveform_pkg::*;
#(
    parameter logic [31:0] CMD_WORD    = WFRM_CMD_WORD,
    parameter int unsigned CHUNK_WORDS = 251
) (
    input  logic        axi_tclk,
    input  logic        axi_tresetn,
    input  logic        start,
    input  logic [31:0] wfrm_len,
    output logic        busy,
    output logic [31:0] wfrm_id,
    input  logic [31:0] smpl_axis_tdata,
    input  logic        smpl_axis_tvalid,
    output logic        smpl_axis_tready,
    output logic [31:0] wfrm_axis_tdata,
    output logic        wfrm_axis_tvalid,
    output logic        wfrm_axis_tlast,
    output logic [3:0]  wfrm_axis_tkeep,
    input  logic        wfrm_axis_tready
);

    localparam logic [31:0] CHUNK_MAX = 32'(CHUNK_WORDS);

    wfrm_state_e state_q, state_d;
    logic [2:0]  hdr_cnt_q,   hdr_cnt_d;
    logic [31:0] remaining_q, remaining_d;
    logic [31:0] index_q,     index_d;
    logic [31:0] pay_cnt_q,   pay_cnt_d;
    logic [31:0] id_q,        id_d;
`ifdef WFPKT_CHECKSUM_EN
    logic [31:0] sum_q,       sum_d;
`endif

    logic [31:0] chunk_len;
    logic        slot_ready;
    logic        push_valid;
    logic [31:0] push_data;
    logic        push_last;
    logic        push;

    assign chunk_len = (remaining_q > CHUNK_MAX) ? CHUNK_MAX : remaining_q;
    assign push      = push_valid && slot_ready;
    assign busy      = (state_q != ST_IDLE);
    assign wfrm_id   = id_q;

    // State register
    always_ff @(posedge axi_tclk or negedge axi_tresetn) begin
        if (!axi_tresetn) begin
            state_q     <= ST_IDLE;
            hdr_cnt_q   <= '0;
            remaining_q <= '0;
            index_q     <= '0;
            pay_cnt_q   <= '0;
            id_q        <= '0;
`ifdef WFPKT_CHECKSUM_EN
            sum_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            hdr_cnt_q   <= hdr_cnt_d;
            remaining_q <= remaining_d;
            index_q     <= index_d;
            pay_cnt_q   <= pay_cnt_d;
            id_q        <= id_d;
`ifdef WFPKT_CHECKSUM_EN
            sum_q       <= sum_d;
`endif
        end
    end

    // Next-state logic. All transitions advance only when the offered word is
    // actually taken by the output slot.
    always_comb begin
        state_d     = state_q;
        hdr_cnt_d   = hdr_cnt_q;
        remaining_d = remaining_q;
        index_d     = index_q;
        pay_cnt_d   = pay_cnt_q;
        id_d        = id_q;
`ifdef WFPKT_CHECKSUM_EN
        sum_d       = sum_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    remaining_d = wfrm_len;
                    index_d     = '0;
                    state_d     = ST_HDR;
                    // Word 0 goes out together with start when the slot is
                    // free, giving first-word-valid one cycle after start.
                    hdr_cnt_d   = push ? 3'd1 : 3'd0;
                end
            end
            ST_HDR: begin
                if (push) begin
                    if (hdr_cnt_q == HDR_IDX_LAST) begin
                        hdr_cnt_d = '0;
`ifdef WFPKT_CHECKSUM_EN
                        sum_d     = '0;
`endif
                        if (chunk_len == '0) begin
`ifdef WFPKT_CHECKSUM_EN
                            state_d = ST_TRAIL;
`else
                            state_d = ST_IDLE;
                            id_d    = id_q + 32'd1;
`endif
                        end else begin
                            pay_cnt_d = chunk_len;
                            state_d   = ST_PAYLOAD;
                        end
                    end else begin
                        hdr_cnt_d = hdr_cnt_q + 3'd1;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (push) begin
                    remaining_d = remaining_q - 32'd1;
                    pay_cnt_d   = pay_cnt_q - 32'd1;
`ifdef WFPKT_CHECKSUM_EN
                    sum_d       = sum_q + smpl_axis_tdata;
                    if (pay_cnt_q == 32'd1) begin
                        state_d = ST_TRAIL;
                    end
`else
                    if (pay_cnt_q == 32'd1) begin
                        if (remaining_q != 32'd1) begin
                            index_d = index_q + 32'd1;
                            state_d = ST_HDR;
                        end else begin
                            state_d = ST_IDLE;
                            id_d    = id_q + 32'd1;
                        end
                    end
`endif
                end
            end
`ifdef WFPKT_CHECKSUM_EN
            ST_TRAIL: begin
                if (push) begin
                    if (remaining_q != '0) begin
                        index_d = index_q + 32'd1;
                        state_d = ST_HDR;
                    end else begin
                        state_d = ST_IDLE;
                        id_d    = id_q + 32'd1;
                    end
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output logic: the word offered to the slot and the sample-side ready.
    always_comb begin
        push_valid       = 1'b0;
        push_data        = '0;
        push_last        = 1'b0;
        smpl_axis_tready = 1'b0;
        case (state_q)
            ST_IDLE: begin
                push_valid = start;
                push_data  = CMD_WORD;
            end
            ST_HDR: begin
                push_valid = 1'b1;
                case (hdr_cnt_q)
                    HDR_IDX_CMD:   push_data = CMD_WORD;
                    HDR_IDX_ID:    push_data = id_q;
                    HDR_IDX_INDEX: push_data = index_q;
                    HDR_IDX_LEN:   push_data = chunk_len;
                    default:       push_data = '0;
                endcase
`ifndef WFPKT_CHECKSUM_EN
                push_last = (hdr_cnt_q == HDR_IDX_LAST) && (chunk_len == '0);
`endif
            end
            ST_PAYLOAD: begin
                push_valid       = smpl_axis_tvalid;
                push_data        = smpl_axis_tdata;
                smpl_axis_tready = slot_ready;
`ifndef WFPKT_CHECKSUM_EN
                push_last        = (pay_cnt_q == 32'd1);
`endif
            end
`ifdef WFPKT_CHECKSUM_EN
            ST_TRAIL: begin
                push_valid = 1'b1;
                push_data  = sum_q;
                push_last  = 1'b1;
            end
`endif
            default: begin
                push_valid = 1'b0;
            end
        endcase
    end

    axis_out_reg #(
        .DATA_W (32)
    ) u_out (
        .clk       (axi_tclk),
        .rst_n     (axi_tresetn),
        .in_valid  (push_valid),
        .in_data   (push_data),
        .in_last   (push_last),
        .in_ready  (slot_ready),
        .out_valid (wfrm_axis_tvalid),
        .out_data  (wfrm_axis_tdata),
        .out_last  (wfrm_axis_tlast),
        .out_keep  (wfrm_axis_tkeep),
        .out_ready (wfrm_axis_tready)
    );

endmodule
